// File: rtl/microwave_controller.sv
// Microwave cooking sequencer: BCD MM:SS cook timer, keypad entry,
// magnetron enable and done indicator, driven by a four-state machine.
module microwave_controller #(
    parameter int unsigned DONE_TICKS = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        startn,
    input  logic        stopn,
    input  logic        clearn,
    input  logic        door_closed,
    input  logic        sec_tick,
    input  logic        key_valid,
    input  logic [3:0]  key_digit,
    output logic [15:0] time_bcd,
    output logic        mag_on,
    output logic        done,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COOK  = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_t;

    localparam logic [3:0] DT = 4'(DONE_TICKS);

    state_t      st_q, st_nx;
    logic [15:0] time_q, time_nx;
    logic [3:0]  cnt_q, cnt_nx;
    logic        start_q, stop_q, clear_q;
    logic        mag_q, mag_nx;
    logic        done_q, done_nx;
    logic        start_c, stop_c, clear_c;
    logic        key_ok;
    logic [15:0] time_dec;

    // Counts down digit-wise; seconds wrap 0 -> 59, no normalisation of >59.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] m10, m1, s10, s1;
        {m10, m1, s10, s1} = t;
        if (s1 != 4'd0) begin
            s1 = s1 - 4'd1;
        end else begin
            s1 = 4'd9;
            if (s10 != 4'd0) begin
                s10 = s10 - 4'd1;
            end else begin
                s10 = 4'd5;
                if (m1 != 4'd0) begin
                    m1 = m1 - 4'd1;
                end else begin
                    m1  = 4'd9;
                    m10 = m10 - 4'd1;
                end
            end
        end
        return {m10, m1, s10, s1};
    endfunction

    assign start_c  = start_q & ~startn;
    assign stop_c   = stop_q  & ~stopn;
    assign clear_c  = clear_q & ~clearn;
    assign key_ok   = key_valid && (key_digit <= 4'd9);
    assign time_dec = bcd_dec(time_q);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= IDLE;
            time_q  <= 16'h0000;
            cnt_q   <= 4'd0;
            start_q <= 1'b1;
            stop_q  <= 1'b1;
            clear_q <= 1'b1;
            mag_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            st_q    <= st_nx;
            time_q  <= time_nx;
            cnt_q   <= cnt_nx;
            start_q <= startn;
            stop_q  <= stopn;
            clear_q <= clearn;
            mag_q   <= mag_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        st_nx   = st_q;
        time_nx = time_q;
        cnt_nx  = cnt_q;
        unique case (st_q)
            IDLE: begin
                if (clear_c) begin
                    time_nx = 16'h0000;
                end else if (start_c) begin
                    // Start sees pre-shift time; a coincident key is dropped.
                    if (door_closed && time_q != 16'h0000)
                        st_nx = COOK;
                end else if (key_ok) begin
                    time_nx = {time_q[11:0], key_digit};
                end
            end
            COOK: begin
                if (clear_c) begin
                    st_nx   = IDLE;
                    time_nx = 16'h0000;
                end else if (stop_c || !door_closed) begin
                    st_nx = PAUSE;
                end else if (sec_tick) begin
                    time_nx = time_dec;
                    if (time_dec == 16'h0000)
                        st_nx = DONE;
                end
            end
            PAUSE: begin
                if (clear_c) begin
                    st_nx   = IDLE;
                    time_nx = 16'h0000;
                end else if (stop_c) begin
                    st_nx = IDLE;
                end else if (start_c && door_closed) begin
                    st_nx = COOK;
                end
            end
            DONE: begin
                if (clear_c || start_c || !door_closed) begin
                    st_nx  = IDLE;
                    cnt_nx = 4'd0;
                end else if (sec_tick) begin
                    if (cnt_q + 4'd1 >= DT) begin
                        st_nx  = IDLE;
                        cnt_nx = 4'd0;
                    end else begin
                        cnt_nx = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                st_nx   = IDLE;
                time_nx = 16'h0000;
                cnt_nx  = 4'd0;
            end
        endcase
    end

    always_comb begin
        mag_nx  = (st_nx == COOK);
        done_nx = (st_nx == DONE);
    end

    assign time_bcd = time_q;
    assign mag_on   = mag_q;
    assign done     = done_q;
    assign state    = st_q;

endmodule

// File: doc/microwave_controller.md
Name: microwave_controller

Overview:
- Top-level cooking sequencer for the microwave: owns the 4-digit BCD cook timer (MM:SS), the keypad digit entry and the magnetron enable.
- Replaces ad-hoc set/reset gating with an explicit state machine driven by start/stop/clear buttons, the door switch and a 1 Hz tick from the clock divider.
- Feeds the 7-segment display drivers and the magnetron/beeper outputs.

Parameters:
DONE_TICKS, 3, number of sec_tick pulses the done indicator stays high before returning to IDLE (1..15)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
startn  input  1  start button, active-low, synchronous to clk
stopn  input  1  stop button, active-low, synchronous to clk
clearn  input  1  clear button, active-low, synchronous to clk
door_closed  input  1  1 = door closed
sec_tick  input  1  one-clk pulse per second
key_valid  input  1  one-clk strobe, key_digit valid
key_digit  input  4  keypad BCD digit
time_bcd  output  16  {min_tens, min_ones, sec_tens, sec_ones}
mag_on  output  1  magnetron enable
done  output  1  cooking-finished indicator / beeper
state  output  3  current state code, for display/debug

Behaviour:
- Reset (rstn low, async): state=IDLE(0), time_bcd=16'h0000, mag_on=0, done=0, button history registers=1, done tick counter=0.
- State codes: IDLE=0, COOK=1, PAUSE=2, DONE=3.
- Buttons act on the falling edge only: cmd = prev high and now low. Holding a button issues one command. Each cycle at most one command is honoured. Priority: clear > stop > door open > start.
- Key entry is accepted only in IDLE with key_valid=1 and key_digit<=9. Action: time_bcd <= {time_bcd[11:0], key_digit}, i.e. shift left one digit. Digits >9 are ignored. Keys in any other state are ignored.
- IDLE:
  - start with door_closed=1 and time_bcd!=0 -> COOK.
  - start with time 0 or door open -> ignored.
- COOK:
  - clear -> IDLE, time_bcd=0.
  - stop -> PAUSE.
  - door_closed=0 -> PAUSE.
  - sec_tick with none of the above -> BCD decrement. sec_ones 0 borrows from sec_tens. sec_tens 0 borrows a minute and sets sec_tens=5, sec_ones=9. Minute digits decrement likewise (min_ones 0 -> 9, borrow min_tens).
  - If the decremented result is 0000, next state = DONE in the same edge.
- Seconds fields above 59 from entry (e.g. 0099) are legal: they count down digit-wise (99, 98, …), with no normalisation.
- PAUSE:
  - clear -> IDLE, time_bcd=0.
  - start with door_closed=1 -> COOK.
  - stop -> IDLE, time retained.
  - sec_tick ignored; time held.
- DONE:
  - done=1.
  - Tick counter increments on sec_tick; on reaching DONE_TICKS -> IDLE with counter=0.
  - clear, start, or door_closed=0 -> IDLE immediately, done=0, counter=0.
  - time_bcd stays 0000.
- Outputs are registered. mag_on=1 exactly while state==COOK, so door open drops mag_on one clk after door_closed falls. done=1 exactly while state==DONE.
- Simultaneous events:
  - sec_tick in the same cycle as a transition out of COOK: no decrement.
  - sec_tick in the cycle of the PAUSE->COOK or IDLE->COOK transition: no decrement.
  - key_valid together with start in IDLE: start is evaluated on the pre-shift time_bcd and the key is discarded.
- rstn asserted mid-cook: immediate return to reset values; mag_on falls asynchronously.

Test Plan:
- Reset, keys 1,3,0 -> time_bcd=16'h0130. start falling edge -> state=1, mag_on=1 next clk. 5 ticks -> 16'h0125.
- Load 0100, start, 1 tick -> 16'h0059. Load 1000, 1 tick -> 16'h0959.
- Load 0002, start, 2 ticks -> 0000, state=3, mag_on=0, done=1 for 3 ticks then state=0. Repeat with start pressed during DONE -> immediate IDLE.
- In COOK at 0030, drop door_closed -> mag_on=0 next clk, state=2. Ticks hold 0030. start with door open ignored. Close door + start -> COOK, first tick -> 0029.
- In COOK: stop -> PAUSE; stop again -> IDLE with time kept; clear -> 0000. Clear and start in the same cycle -> IDLE (clear wins). startn held low for 10 clk -> single command.
- Assert rstn mid-COOK at 0045 -> time 0000, mag_on=0 without waiting for clk. Key 4'hA in IDLE -> no change. start with 0000 -> stays IDLE.
